// File: rtl/mod12_pkg.sv
// mod12_pkg: shared constants, event record and reference-model helper for the
// mod-12 counter event tracker.
package mod12_pkg;

   localparam logic [3:0] MOD12_MAX   = 4'd11;

   localparam logic [1:0] EVT_WRAP_DN = 2'd0;
   localparam logic [1:0] EVT_LOAD    = 2'd1;
   localparam logic [1:0] EVT_WRAP_UP = 2'd2;
   localparam logic [1:0] EVT_ERR     = 2'd3;

   typedef struct packed {
      logic [1:0] code;
      logic [3:0] value;
   } evt_t;

   // Count value the counter must present one cycle after seeing these controls.
   // Plain 4-bit arithmetic so out-of-range values (12..15) step exactly as the counter does.
   function automatic logic [3:0] mod12_expect(input logic       p_rst,
                                               input logic       p_load,
                                               input logic       p_mode,
                                               input logic [3:0] p_din,
                                               input logic [3:0] p_cnt);
      logic [3:0] nxt;
      if (p_rst)
         nxt = 4'd0;
      else if (p_load)
         nxt = p_din;
      else if (p_mode)
         nxt = (p_cnt == MOD12_MAX) ? 4'd0 : p_cnt + 4'd1;
      else
         nxt = (p_cnt == 4'd0) ? MOD12_MAX : p_cnt - 4'd1;
      return nxt;
   endfunction

endpackage

// File: rtl/mod12_event_tracker_fifo.sv
// mod12_evt_fifo: synchronous show-ahead FIFO of evt_t entries. The head entry is
// visible on 'head' whenever 'valid' is high and reads as zero when empty.
// A push is accepted on a full FIFO only when a pop happens on the same edge.
module mod12_evt_fifo
   import mod12_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  evt_t                     push_entry,
   input  logic                     pop,
   output evt_t                     head,
   output logic                     valid,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);

   evt_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          empty;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Pointer and occupancy tracking; reset empties the FIFO regardless of push/pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents need no reset because the pointers gate visibility.
   always_ff @(posedge clk) begin
      if (!rst && do_push)
         mem[wr_ptr] <= push_entry;
   end

   // Show-ahead head; zero while empty.
   always_comb begin
      head = '0;
      if (!empty)
         head = mem[rd_ptr];
   end

   assign valid = !empty;
   assign level = count;

endmodule

// File: rtl/mod12_event_tracker.sv
// mod12_event_tracker: monitor for the loadable up/down mod-12 counter.
// Shadows the counter controls one cycle, classifies each count transition as
// LOAD / WRAP_UP / WRAP_DN / ERR, tracks net wraps and queues events in a FIFO.
// Optional: define MOD12_TRK_ERR_CHECK_EN to enable reference-model ERR detection.
module mod12_event_tracker
   import mod12_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned WRAP_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mode,
   input  logic                     load,
   input  logic [3:0]               data_in,
   input  logic [3:0]               cnt_in,
   input  logic                     evt_ready,
   output logic                     evt_valid,
   output logic [1:0]               evt_code,
   output logic [3:0]               evt_value,
   output logic [WRAP_W-1:0]        wrap_count,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     ovf,
   output logic                     err_seen
);

   logic       p_rst;
   logic       p_load;
   logic       p_mode;
   logic [3:0] p_cnt;

   logic       err_det;
   logic       wrap_up;
   logic       wrap_dn;
   logic       evt_det;
   logic [1:0] det_code;
   logic       pop;
   logic       fifo_full;
   evt_t       head;

   // Shadow of this cycle's counter controls and output, as seen by the counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         p_rst  <= 1'b1;
         p_load <= 1'b0;
         p_mode <= 1'b0;
         p_cnt  <= '0;
      end else begin
         p_rst  <= 1'b0;
         p_load <= load;
         p_mode <= mode;
         p_cnt  <= cnt_in;
      end
   end

`ifdef MOD12_TRK_ERR_CHECK_EN
   logic [3:0] p_din;
   logic [3:0] exp_cnt;

   // Load data shadow; only the reference model consumes it.
   always_ff @(posedge clk) begin
      if (rst)
         p_din <= '0;
      else
         p_din <= data_in;
   end

   assign exp_cnt = mod12_expect(p_rst, p_load, p_mode, p_din, p_cnt);
   assign err_det = (cnt_in != exp_cnt);

   // Sticky record of any reference-model mismatch.
   always_ff @(posedge clk) begin
      if (rst)
         err_seen <= 1'b0;
      else if (err_det)
         err_seen <= 1'b1;
   end
`else
   // Without the reference model, load data has no consumer.
   logic unused_data_in;
   assign unused_data_in = ^data_in;
   assign err_det  = 1'b0;
   assign err_seen = 1'b0;
`endif

   assign wrap_up = !p_rst && !p_load &&  p_mode && (p_cnt == MOD12_MAX) && (cnt_in == 4'd0);
   assign wrap_dn = !p_rst && !p_load && !p_mode && (p_cnt == 4'd0)      && (cnt_in == MOD12_MAX);

   // Priority classifier: at most one event per cycle, ERR first.
   always_comb begin
      evt_det  = 1'b0;
      det_code = EVT_WRAP_DN;
      if (err_det) begin
         evt_det  = 1'b1;
         det_code = EVT_ERR;
      end else if (p_load && !p_rst) begin
         evt_det  = 1'b1;
         det_code = EVT_LOAD;
      end else if (wrap_up) begin
         evt_det  = 1'b1;
         det_code = EVT_WRAP_UP;
      end else if (wrap_dn) begin
         evt_det  = 1'b1;
         det_code = EVT_WRAP_DN;
      end
   end

   // Net wrap count; counts even when the event itself is dropped, never on ERR.
   always_ff @(posedge clk) begin
      if (rst)
         wrap_count <= '0;
      else if (!err_det && wrap_up)
         wrap_count <= wrap_count + WRAP_W'(1);
      else if (!err_det && wrap_dn)
         wrap_count <= wrap_count - WRAP_W'(1);
   end

   assign pop = evt_valid && evt_ready;

   // Sticky overflow: an event arrived while full with no pop to make room.
   always_ff @(posedge clk) begin
      if (rst)
         ovf <= 1'b0;
      else if (evt_det && fifo_full && !pop)
         ovf <= 1'b1;
   end

   mod12_evt_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (evt_det),
      .push_entry ('{code: det_code, value: cnt_in}),
      .pop        (pop),
      .head       (head),
      .valid      (evt_valid),
      .full       (fifo_full),
      .level      (fifo_level)
   );

   assign evt_code  = head.code;
   assign evt_value = head.value;

endmodule

// File: tb/tb_mod12_event_tracker.sv
// Self-checking bench for mod12_event_tracker. A behavioural counter drives cnt_in;
// expected events are queued as stimulus is applied and compared as they are popped.
// Honours MOD12_TRK_ERR_CHECK_EN the same way as the design.
module tb_mod12_event_tracker;
   import mod12_pkg::*;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned WRAP_W = 8;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   mode;
   logic                   load;
   logic [3:0]             data_in;
   logic [3:0]             cnt_in;
   logic                   evt_ready;
   logic                   evt_valid;
   logic [1:0]             evt_code;
   logic [3:0]             evt_value;
   logic [WRAP_W-1:0]      wrap_count;
   logic [$clog2(DEPTH):0] fifo_level;
   logic                   ovf;
   logic                   err_seen;

   int   checks = 0;
   int   errors = 0;
   logic [3:0] cnt = 4'd0;
   evt_t exp_q[$];

   mod12_event_tracker #(
      .DEPTH  (DEPTH),
      .WRAP_W (WRAP_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mode       (mode),
      .load       (load),
      .data_in    (data_in),
      .cnt_in     (cnt_in),
      .evt_ready  (evt_ready),
      .evt_valid  (evt_valid),
      .evt_code   (evt_code),
      .evt_value  (evt_value),
      .wrap_count (wrap_count),
      .fifo_level (fifo_level),
      .ovf        (ovf),
      .err_seen   (err_seen)
   );

   always #5 clk = ~clk;

   // Advance one clock; the behavioural counter reacts to the controls sampled at the edge.
   task automatic step();
      @(posedge clk);
      if (rst)
         cnt = 4'd0;
      else if (load)
         cnt = data_in;
      else if (mode)
         cnt = (cnt == 4'd11) ? 4'd0 : cnt + 4'd1;
      else
         cnt = (cnt == 4'd0) ? 4'd11 : cnt - 4'd1;
      #1;
      cnt_in = cnt;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      load = 1'b0;
      step();
      rst = 1'b0;
      exp_q.delete();
   endtask

   // Scoreboard: every accepted pop must match the oldest expected event.
   always @(negedge clk) begin
      if (!rst && evt_valid && evt_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event_unexpected: got code=%0d value=%0d, required no event", evt_code, evt_value);
         end else begin
            evt_t e;
            e = exp_q.pop_front();
            if ({evt_code, evt_value} !== {e.code, e.value}) begin
               errors++;
               $display("FAIL event_order: got code=%0d value=%0d, required code=%0d value=%0d",
                        evt_code, evt_value, e.code, e.value);
            end
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1; load = 1'b0; mode = 1'b1; data_in = 4'd0; cnt_in = 4'd0; evt_ready = 1'b1;
      step();
      step();
      checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", evt_valid); end
      checks++; if (fifo_level !== '0) begin errors++; $display("FAIL reset_level: got %0d, required 0", fifo_level); end
      checks++; if (wrap_count !== '0) begin errors++; $display("FAIL reset_wrap: got %0d, required 0", wrap_count); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b, required 0", ovf); end
      checks++; if (err_seen !== 1'b0) begin errors++; $display("FAIL reset_err_seen: got %b, required 0", err_seen); end
      rst = 1'b0;
   endtask

   task automatic test_count_up();
      do_reset();
      mode = 1'b1; evt_ready = 1'b1;
      exp_q.push_back('{code: EVT_WRAP_UP, value: 4'd0});
      repeat (12) step();
      step();
      checks++; if (wrap_count !== 8'd1) begin errors++; $display("FAIL up_wrap_count: got %0d, required 1", wrap_count); end
      for (int i = 0; i < 8 && exp_q.size() != 0; i++) step();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL up_drain: got %0d pending, required 0", exp_q.size()); end
      checks++; if (err_seen !== 1'b0) begin errors++; $display("FAIL up_err_seen: got %b, required 0", err_seen); end
   endtask

   task automatic test_load_down();
      do_reset();
      evt_ready = 1'b1; mode = 1'b0; load = 1'b1; data_in = 4'd5;
      exp_q.push_back('{code: EVT_LOAD, value: 4'd5});
      step();
      load = 1'b0;
      exp_q.push_back('{code: EVT_WRAP_DN, value: 4'd11});
      repeat (6) step();
      step();
      checks++; if (wrap_count !== 8'hFF) begin errors++; $display("FAIL dn_wrap_count: got %h, required ff", wrap_count); end
      for (int i = 0; i < 8 && exp_q.size() != 0; i++) step();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL dn_drain: got %0d pending, required 0", exp_q.size()); end
   endtask

   task automatic test_err();
      do_reset();
      evt_ready = 1'b1; mode = 1'b1;
      repeat (3) step();
`ifdef MOD12_TRK_ERR_CHECK_EN
      exp_q.push_back('{code: EVT_ERR, value: 4'd7});
`endif
      step();
      cnt = 4'd7;
      cnt_in = 4'd7;
      step();
`ifdef MOD12_TRK_ERR_CHECK_EN
      checks++; if (err_seen !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b, required 1", err_seen); end
`else
      checks++; if (err_seen !== 1'b0) begin errors++; $display("FAIL err_tied: got %b, required 0", err_seen); end
`endif
      for (int i = 0; i < 3 && exp_q.size() != 0; i++) step();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL err_drain: got %0d pending, required 0", exp_q.size()); end
      checks++; if (wrap_count !== '0) begin errors++; $display("FAIL err_wrap: got %0d, required 0", wrap_count); end
   endtask

   task automatic test_overflow();
      do_reset();
      evt_ready = 1'b0; mode = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         load = 1'b1;
         data_in = 4'(7 + i);
         if (i < DEPTH) exp_q.push_back('{code: EVT_LOAD, value: 4'(7 + i)});
         step();
      end
      load = 1'b0;
      step();
      step();
      checks++; if (fifo_level !== 3'(DEPTH)) begin errors++; $display("FAIL ovf_level: got %0d, required %0d", fifo_level, DEPTH); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b, required 1", ovf); end
      evt_ready = 1'b1;
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_drain: got %0d pending, required 0", exp_q.size()); end
      checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b, required 0", evt_valid); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, required 1", ovf); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      evt_ready = 1'b0; mode = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         load = 1'b1;
         data_in = 4'(7 + i);
         exp_q.push_back('{code: EVT_LOAD, value: 4'(7 + i)});
         step();
      end
      load = 1'b0;
      checks++; if (fifo_level !== 3'(DEPTH)) begin errors++; $display("FAIL b2b_full: got %0d, required %0d", fifo_level, DEPTH); end
      evt_ready = 1'b1;
      step();
      checks++; if (fifo_level !== 3'(DEPTH)) begin errors++; $display("FAIL b2b_level: got %0d, required %0d", fifo_level, DEPTH); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b, required 0", ovf); end
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending, required 0", exp_q.size()); end
      checks++; if (fifo_level !== '0) begin errors++; $display("FAIL b2b_empty: got %0d, required 0", fifo_level); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      evt_ready = 1'b0; mode = 1'b0;
      exp_q.push_back('{code: EVT_WRAP_DN, value: 4'd11});
      step();
      load = 1'b1; data_in = 4'd5; exp_q.push_back('{code: EVT_LOAD, value: 4'd5});
      step();
      data_in = 4'd6; exp_q.push_back('{code: EVT_LOAD, value: 4'd6});
      step();
      load = 1'b0;
      step();
      step();
      checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL mid_level_pre: got %0d, required 3", fifo_level); end
      checks++; if (wrap_count !== 8'hFF) begin errors++; $display("FAIL mid_wrap_pre: got %h, required ff", wrap_count); end
      rst = 1'b1;
      exp_q.delete();
      step();
      checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b, required 0", evt_valid); end
      checks++; if (fifo_level !== '0) begin errors++; $display("FAIL mid_level: got %0d, required 0", fifo_level); end
      checks++; if (wrap_count !== '0) begin errors++; $display("FAIL mid_wrap: got %0d, required 0", wrap_count); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL mid_ovf: got %b, required 0", ovf); end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_load_down();
      test_err();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      step();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue: got %0d pending, required 0", exp_q.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
